pipe_add_arbiter: RTL and testbench
===================================

# pipe_add_arbiter

Round-robin arbiter and sequencer that shares one 8-bit, 5-stage pipelined adder among NREQ requesters. Each requester presents operands through a valid/ready handshake. The block issues at most one operation per clock into the adder and tracks the owner of each in-flight operation with a tag pipeline. When the sum leaves the adder, the block routes it back to the owning requester. The block sits between the client logic and the existing pipelined adder instance, which it drives directly and which has no stall capability.

## Interface
- NREQ, 4: number of requesters, range 2..8
- W, 8: operand width; fixed to match the adder
- LAT, 5: adder latency in clocks from operand sample to valid sum
- MAX_OUT, 2: maximum in-flight operations per requester, range 1..LAT
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester operation request
- req_ready  out  NREQ  one-hot grant; a transfer occurs when req_valid[i] && req_ready[i]
- req_a  in  NREQ*W  operand A, requester i in bits [i*W +: W]
- req_b  in  NREQ*W  operand B, same packing
- req_cin  in  NREQ  carry-in per requester
- add_ina, add_inb  out  W  operands to the adder
- add_cin  out  1  carry-in to the adder
- add_sum  in  W  sum from the adder
- add_cout  in  1  carry-out from the adder
- rsp_valid  out  NREQ  one-hot result strobe, one cycle per result; no back-pressure
- rsp_sum  out  W  result sum, valid when any rsp_valid bit is set
- rsp_cout  out  1  result carry-out

## Operation
- **Eligibility:** requester i is eligible when req_valid[i] is high and either:
  - out_cnt[i] < MAX_OUT, or
  - a response for i is returning this cycle (same-cycle credit bypass).
- **Arbitration:** round-robin over eligible requesters, starting at pointer rr_ptr.
  - At most one req_ready bit is high per cycle.
  - On a grant to requester g, rr_ptr becomes (g+1) mod NREQ. Without a grant, rr_ptr holds.
- **Combinational path:** req_ready may depend combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
- **Adder drive:** in a grant cycle, add_ina, add_inb and add_cin carry the granted requester's operands combinationally. With no grant they are driven 0.
- **Tag pipeline:** LAT entries, each {vld, id[$clog2(NREQ)-1:0]}, shifting every clock.
  - The head is loaded with {grant, g}.
  - The tail aligns exactly with add_sum/add_cout.
- **Response:** rsp_valid[tail.id] = tail.vld. rsp_sum and rsp_cout pass add_sum and add_cout through when tail.vld is set and are 0 otherwise.
- **out_cnt[i]:**
  - +1 on a grant to i.
  - −1 on a response to i.
  - Unchanged when both occur in the same cycle.
  - Never exceeds MAX_OUT and never underflows. Verification asserts both.
- **Arithmetic:** the block does no arithmetic of its own. {rsp_cout, rsp_sum} is exactly the adder's 9-bit result (a + b + cin).
- **Reset:**
  - rst high for one or more edges clears all tag vld bits, all out_cnt and rr_ptr.
  - In-flight adder results are discarded: the adder itself is not reset, but its outputs are never flagged valid.
  - req_ready is held 0 while rst is high.

## Timing
- Handshake in cycle T means add_ina/add_inb/add_cin are sampled by the adder at the end of T.
- rsp_valid for that handshake rises in cycle T+LAT (T+5) for exactly one cycle.
- Sustained throughput is one grant per cycle across all requesters.
- Per-requester throughput is MAX_OUT grants per LAT cycles.
- Responses return in global issue order. There is no reordering.
- Reset values:
  - req_ready, rsp_valid: all 0
  - rsp_sum, rsp_cout: 0
  - add_ina, add_inb, add_cin: 0
- First grant possible in the first cycle after rst deasserts.
- Reset mid-operation: no rsp_valid may appear in any cycle for operations granted before the reset edge.

## Structure
- Package pipe_add_pkg:
  - W, LAT constants
  - tag_t struct {logic vld; logic [IDW-1:0] id}
  - localparam IDW function of NREQ
- Sub-module rr_arbiter: inputs req[NREQ] and ptr; outputs one-hot gnt and an encoded index.
- Tag shift register and counters live in the top module.

## Test plan
- **Single request:** requester 2, a=0x5A, b=0x33, cin=1 at T → rsp_valid=4'b0100 at T+5, rsp_sum=0x8E, rsp_cout=0.
- **Carry-out:** requester 0, a=0xFF, b=0x01, cin=0 → rsp_sum=0x00, rsp_cout=1 at T+5.
- **All four requesters held valid for 8 cycles** from rr_ptr=0 → grants 0,1,2,3,0,1,2,3 on consecutive cycles; responses in the same order at T+5..T+12.
- **Credit limit with bypass:** MAX_OUT=2, requester 1 held valid alone from T → grants at T, T+1, T+5, T+6, T+10, T+11; out_cnt never exceeds 2.
- **Reset mid-flight:** grants at T, T+1, then rst high during T+2 → no rsp_valid at T+5/T+6; out_cnt=0 and rr_ptr=0 after reset; new request at T+3 answered at T+8.
- **Idle drive:** no req_valid for 10 cycles → add_ina=add_inb=0, add_cin=0, rsp_valid=0 throughout.

Source files
------------

// File: rtl/pipe_add_pkg.sv
// Shared constants and types for the pipelined-adder arbiter slice.
package pipe_add_pkg;

  localparam int unsigned W        = 8;
  localparam int unsigned LAT      = 5;
  localparam int unsigned NREQ_MAX = 8;
  // Sized for the largest legal requester count so one tag type serves every NREQ.
  localparam int unsigned IDW      = $clog2(NREQ_MAX);

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } tag_t;

  function automatic logic [IDW-1:0] rr_next(input logic [IDW-1:0] g, input int unsigned n);
    return (g == IDW'(n - 1)) ? '0 : g + 1'b1;
  endfunction

endpackage

// File: rtl/pipe_add_arbiter_rr.sv
// Round-robin picker: first set request at or after ptr_i, wrapping modulo N.
module rr_arbiter
  import pipe_add_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] idx_o,
  output logic           any_o
);

  always_comb begin
    int unsigned c;
    c     = 0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      c = (32'(ptr_i) + k) % N;
      if (!any_o && req_i[c]) begin
        gnt_o[c] = 1'b1;
        idx_o    = IDW'(c);
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_add_arbiter.sv
// Shares one LAT-stage pipelined adder among NREQ requesters; a tag pipeline
// alongside the adder routes each sum back to the requester that issued it.
module pipe_add_arbiter
  import pipe_add_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned MAX_OUT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
  output logic [W-1:0]      add_ina,
  output logic [W-1:0]      add_inb,
  output logic              add_cin,
  input  logic [W-1:0]      add_sum,
  input  logic              add_cout,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W-1:0]      rsp_sum,
  output logic              rsp_cout
);

  localparam int unsigned CW = $clog2(MAX_OUT + 1);

  tag_t            tag_q [LAT];
  tag_t            tail;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   cnt_q [NREQ];
  logic [CW-1:0]   cnt_d [NREQ];
  logic [NREQ-1:0] rsp_hit, elig, gnt;
  logic [IDW-1:0]  gidx;
  logic            gany;

  assign tail = tag_q[LAT-1];

  // A returning response frees its credit in the same cycle it can be reused.
  always_comb begin
    rsp_hit = '0;
    elig    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      rsp_hit[i] = tail.vld && (tail.id == IDW'(i)) && !rst;
      elig[i]    = req_valid[i] && !rst &&
                   ((cnt_q[i] < CW'(MAX_OUT)) || rsp_hit[i]);
    end
  end

  rr_arbiter #(.N(NREQ)) u_rr (
    .req_i (elig),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gidx),
    .any_o (gany)
  );

  assign req_ready = gnt;

  always_comb begin
    add_ina = '0;
    add_inb = '0;
    add_cin = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        add_ina = req_a[i*W +: W];
        add_inb = req_b[i*W +: W];
        add_cin = req_cin[i];
      end
    end
  end

  assign rsp_valid = rsp_hit;
  assign rsp_sum   = (tail.vld && !rst) ? add_sum  : '0;
  assign rsp_cout  = (tail.vld && !rst) ? add_cout : 1'b0;

  always_comb begin
    rr_ptr_d = gany ? rr_next(gidx, NREQ) : rr_ptr_q;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cnt_d[i] = cnt_q[i];
      case ({gnt[i], rsp_hit[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + 1'b1;
        2'b01:   cnt_d[i] = cnt_q[i] - 1'b1;
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      for (int unsigned k = 0; k < LAT; k++) tag_q[k] <= '0;
      for (int unsigned i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      tag_q[0] <= '{vld: gany, id: gidx};
      for (int unsigned k = 1; k < LAT; k++) tag_q[k] <= tag_q[k-1];
      for (int unsigned i = 0; i < NREQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: tb/tb_pipe_add_arbiter.sv
// Bench for pipe_add_arbiter: behavioural adder, queue-based reference model.
module tb_pipe_add_arbiter;
  import pipe_add_pkg::*;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned MAX_OUT = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid, req_ready, req_cin, rsp_valid;
  logic [NREQ*W-1:0] req_a, req_b;
  logic [W-1:0]      add_ina, add_inb, add_sum, rsp_sum;
  logic              add_cin, add_cout, rsp_cout;

  always #5 clk = ~clk;

  pipe_add_arbiter #(.NREQ(NREQ), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .add_ina(add_ina), .add_inb(add_inb), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout)
  );

  // Stall-free pipelined adder, deliberately not reset.
  logic [W-1:0] pa [LAT];
  logic [W-1:0] pb [LAT];
  logic         pc [LAT];
  always @(posedge clk) begin
    pa[0] <= add_ina; pb[0] <= add_inb; pc[0] <= add_cin;
    for (int k = 1; k < LAT; k++) begin
      pa[k] <= pa[k-1]; pb[k] <= pb[k-1]; pc[k] <= pc[k-1];
    end
  end
  assign {add_cout, add_sum} = {1'b0, pa[LAT-1]} + {1'b0, pb[LAT-1]} + {8'b0, pc[LAT-1]};

  typedef struct {
    int unsigned id;
    logic [8:0]  res;
    int unsigned due;
  } inflight_t;

  inflight_t   m_q[$];
  int unsigned m_ptr;
  int unsigned m_cnt [NREQ];
  int unsigned cyc;
  int          checks = 0;
  int          errors = 0;

  logic [NREQ-1:0] obs_ready, obs_rspv;
  logic [W-1:0]    obs_sum;
  logic            obs_cout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: apply inputs, compare outputs against the model, advance the model.
  task automatic step(input logic r, input logic [NREQ-1:0] v);
    logic [NREQ-1:0] e_rsp, e_gnt;
    logic [8:0]      e_res, g_res;
    logic [W-1:0]    ea, eb;
    logic            ec;
    int              gi;
    int unsigned     c;
    inflight_t       it;
    rst = r;
    req_valid = v;
    @(negedge clk);
    e_rsp = '0; e_gnt = '0; e_res = '0; ea = '0; eb = '0; ec = 1'b0; gi = -1;
    if (!r && m_q.size() > 0 && m_q[0].due == cyc) begin
      e_rsp[m_q[0].id] = 1'b1;
      e_res = m_q[0].res;
    end
    if (!r) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        c = (m_ptr + k) % NREQ;
        if (gi < 0 && v[c] && (m_cnt[c] < MAX_OUT || e_rsp[c])) gi = int'(c);
      end
    end
    if (gi >= 0) begin
      e_gnt[gi] = 1'b1;
      ea = req_a[gi*W +: W];
      eb = req_b[gi*W +: W];
      ec = req_cin[gi];
    end
    check("req_ready", 32'(req_ready), 32'(e_gnt));
    check("add_ina",   32'(add_ina),   32'(ea));
    check("add_inb",   32'(add_inb),   32'(eb));
    check("add_cin",   32'(add_cin),   32'(ec));
    check("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
    check("rsp_sum",   32'(rsp_sum),   32'(e_res[7:0]));
    check("rsp_cout",  32'(rsp_cout),  32'(e_res[8]));
    for (int i = 0; i < NREQ; i++) check("out_cnt", 32'(dut.cnt_q[i]), m_cnt[i]);
    obs_ready = req_ready; obs_rspv = rsp_valid; obs_sum = rsp_sum; obs_cout = rsp_cout;
    if (r) begin
      m_ptr = 0;
      for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
      m_q.delete();
    end else begin
      if (m_q.size() > 0 && m_q[0].due == cyc) begin
        m_cnt[m_q[0].id]--;
        void'(m_q.pop_front());
      end
      if (gi >= 0) begin
        g_res = {1'b0, ea} + {1'b0, eb} + {8'b0, ec};
        it.id = int'(gi); it.res = g_res; it.due = cyc + LAT;
        m_q.push_back(it);
        m_cnt[gi]++;
        m_ptr = (int'(gi) + 1) % NREQ;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = W'($urandom);
      req_b[i*W +: W] = W'($urandom);
      req_cin[i]      = 1'($urandom);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0);
  endtask

  initial begin
    logic [11:0] pat;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_cin = '0;
    cyc = 0; m_ptr = 0;
    for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    step(1'b1, '0);
    check("rst_ptr", 32'(dut.rr_ptr_q), 32'd0);
    idle(10);

    // single request, requester 2
    req_a[2*W +: W] = 8'h5A; req_b[2*W +: W] = 8'h33; req_cin = 4'b0100;
    step(1'b0, 4'b0100);
    check("single_gnt", 32'(obs_ready), 32'h4);
    idle(4);
    step(1'b0, '0);
    check("single_rspv", 32'(obs_rspv), 32'h4);
    check("single_sum",  32'(obs_sum),  32'h8E);
    check("single_cout", 32'(obs_cout), 32'd0);

    // carry-out, requester 0
    req_a[0 +: W] = 8'hFF; req_b[0 +: W] = 8'h01; req_cin = '0;
    step(1'b0, 4'b0001);
    idle(4);
    step(1'b0, '0);
    check("carry_rspv", 32'(obs_rspv), 32'h1);
    check("carry_sum",  32'(obs_sum),  32'h00);
    check("carry_cout", 32'(obs_cout), 32'd1);

    // all four held valid from rr_ptr=0
    step(1'b1, '0);
    check("rr_ptr0", 32'(dut.rr_ptr_q), 32'd0);
    rand_ops();
    for (int k = 0; k < 13; k++) begin
      step(1'b0, (k < 8) ? 4'hF : 4'h0);
      if (k < 8)  check("rr_order", 32'(obs_ready), 32'(1 << (k % 4)));
      if (k >= 5) check("rr_rsp",   32'(obs_rspv),  32'(1 << ((k - 5) % 4)));
    end

    // credit limit with same-cycle bypass, requester 1 alone
    idle(6);
    pat = 12'b110001100011;
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 4'b0010);
      check("credit_gnt", 32'(obs_ready[1]), 32'(pat[k]));
    end

    // reset mid-flight
    idle(6);
    step(1'b0, 4'b0001);
    step(1'b0, 4'b0010);
    step(1'b1, '0);
    check("midrst_ptr",  32'(dut.rr_ptr_q), 32'd0);
    check("midrst_cnt0", 32'(dut.cnt_q[0]), 32'd0);
    check("midrst_cnt1", 32'(dut.cnt_q[1]), 32'd0);
    step(1'b0, 4'b0100);
    for (int k = 4; k <= 8; k++) begin
      step(1'b0, '0);
      if (k == 5 || k == 6) check("midrst_quiet", 32'(obs_rspv), 32'd0);
      if (k == 8)           check("midrst_new",   32'(obs_rspv), 32'h4);
    end

    // randomized traffic with occasional reset
    for (int k = 0; k < 3000; k++) begin
      rand_ops();
      step(($urandom_range(149) == 0), NREQ'($urandom));
    end
    idle(LAT + 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
